rsa_req_arbiter: RTL and testbench

//  Shares one rsa_top modular-exponentiation core between NREQ requesters.

---
 rtl/rsa_req_arbiter.sv | 155 +++++++++++++++
 tb/tb_rsa_req_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_req_arbiter.sv
// rsa_req_arbiter: shares one rsa_top modular-exponentiation core between NREQ
// requesters. A round-robin pick captures the winner's key/data/n, runs the core's
// level start/done handshake, and returns the result (or an error) to that requester.
// Operands with n<2 are rejected without starting the core. A watchdog aborts a
// job that waits too long for core_done.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req[NREQ]                 per-requester request level
//   req_key/req_data/req_n    flattened operands, requester i at [i*W +: W]
//   ack[NREQ]                 combinational one-cycle accept pulse (IDLE only)
//   rsp_valid[NREQ]           one-cycle response pulse for the granted requester
//   rsp_result, rsp_err       response payload, held between pulses
//   busy                      high whenever the FSM is not in IDLE
//   core_start/key/data/n     to rsa_top; operands stable from ISSUE through DRAIN
//   core_done, core_result    from rsa_top
module rsa_req_arbiter #(
  parameter int unsigned W           = 6,
  parameter int unsigned NREQ        = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_key,
  input  logic [NREQ*W-1:0] req_data,
  input  logic [NREQ*W-1:0] req_n,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_result,
  output logic              rsp_err,
  output logic              busy,
  output logic              core_start,
  output logic [W-1:0]      core_key,
  output logic [W-1:0]      core_data,
  output logic [W-1:0]      core_n,
  input  logic              core_done,
  input  logic [W-1:0]      core_result
);

  localparam int unsigned    PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned    WDW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);
  localparam logic [WDW-1:0]  WD_LAST  = WDW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t         state;
  state_t         state_d;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  gnt;
  logic           found;
  logic [WDW-1:0] wdog;
  logic [W-1:0]   sel_key;
  logic [W-1:0]   sel_data;
  logic [W-1:0]   sel_n;

  // Round-robin search: first requester after the last grant, wrapping around.
  always_comb begin
    gnt   = ptr;
    found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!found && req[PW'((32'(ptr) + k) % NREQ)]) begin
        found = 1'b1;
        gnt   = PW'((32'(ptr) + k) % NREQ);
      end
    end
  end

  assign sel_key  = req_key[32'(gnt) * W +: W];
  assign sel_data = req_data[32'(gnt) * W +: W];
  assign sel_n    = req_n[32'(gnt) * W +: W];

  // Next-state and the combinational accept pulse.
  always_comb begin
    state_d = state;
    ack     = '0;
    case (state)
      IDLE: begin
        if (found && !rst) begin
          ack     = ONE_HOT0 << gnt;
          state_d = (sel_n < W'(2)) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (core_done || (wdog == WD_LAST)) state_d = RESP;
      end
      RESP:  state_d = DRAIN;
      // Never let a new start overlap a done left over from the previous job.
      DRAIN: begin
        if (!core_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus the registered datapath/outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= PW'(NREQ - 1);
      wdog       <= '0;
      busy       <= 1'b0;
      core_start <= 1'b0;
      core_key   <= '0;
      core_data  <= '0;
      core_n     <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state      <= state_d;
      busy       <= (state_d != IDLE);
      core_start <= (state_d == ISSUE);
      rsp_valid  <= '0;
      case (state)
        IDLE: begin
          if (state_d != IDLE) begin
            ptr       <= gnt;
            core_key  <= sel_key;
            core_data <= sel_data;
            core_n    <= sel_n;
            wdog      <= '0;
            // Degenerate modulus: answer immediately with an error.
            if (state_d == RESP) begin
              rsp_valid  <= ONE_HOT0 << gnt;
              rsp_result <= '0;
              rsp_err    <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (core_done) begin
            rsp_valid  <= ONE_HOT0 << ptr;
            rsp_result <= core_result;
            rsp_err    <= 1'b0;
          end else if (state_d == RESP) begin
            rsp_valid  <= ONE_HOT0 << ptr;
            rsp_result <= '0;
            rsp_err    <= 1'b1;
          end else begin
            wdog <= wdog + WDW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_req_arbiter.sv
// Self-checking bench for rsa_req_arbiter with a behavioural rsa_top model whose
// latency, never-done and done-hold behaviour are programmable.
module tb_rsa_req_arbiter;
  localparam int unsigned W    = 6;
  localparam int unsigned NREQ = 2;
  localparam int unsigned TO   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] req_key = '0;
  logic [NREQ*W-1:0] req_data = '0;
  logic [NREQ*W-1:0] req_n = '0;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_result;
  logic              rsp_err;
  logic              busy;
  logic              core_start;
  logic [W-1:0]      core_key;
  logic [W-1:0]      core_data;
  logic [W-1:0]      core_n;
  logic              core_done = 1'b0;
  logic [W-1:0]      core_result = '0;

  int errors = 0;
  int checks = 0;

  // core model controls
  int lat = 3;
  int lat_cur = 3;
  int cnt = 0;
  bit never = 1'b0;
  int extra_hold = 0;
  int hold_cnt = 0;

  rsa_req_arbiter #(.W(W), .NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_key(req_key), .req_data(req_data),
    .req_n(req_n), .ack(ack), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .busy(busy), .core_start(core_start), .core_key(core_key),
    .core_data(core_data), .core_n(core_n), .core_done(core_done),
    .core_result(core_result)
  );

  always #5 clk = ~clk;

  function automatic int modexp(input int d, input int k, input int n);
    int r;
    if (n < 2) return 0;
    r = 1 % n;
    for (int i = 0; i < k; i++) r = (r * d) % n;
    return r;
  endfunction

  // Round-robin reference: first requester after 'last', wrapping.
  function automatic int rr(input logic [1:0] r, input int last);
    int idx;
    for (int k = 1; k <= 2; k++) begin
      idx = (last + k) % 2;
      if (r[idx[0]]) return idx;
    end
    return -1;
  endfunction

  // Behavioural rsa_top: done 'lat' cycles after start rises, held while start is
  // high, then kept for extra_hold more cycles after start falls.
  always @(posedge clk) begin
    if (core_start) begin
      hold_cnt <= 0;
      if (!never) begin
        if (cnt + 1 >= lat_cur) begin
          core_done   <= 1'b1;
          core_result <= W'(modexp(int'(core_data), int'(core_key), int'(core_n)));
        end
        cnt <= cnt + 1;
      end
    end else begin
      cnt     <= 0;
      lat_cur <= lat;
      if (core_done) begin
        if (hold_cnt >= extra_hold) core_done <= 1'b0;
        else hold_cnt <= hold_cnt + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input int d, input int k, input int n);
    req_data[i*W +: W] = W'(d);
    req_key[i*W +: W]  = W'(k);
    req_n[i*W +: W]    = W'(n);
  endtask

  task automatic wait_rsp(input int maxc, output int waited, output int starts);
    waited = 0;
    starts = 0;
    while (rsp_valid == '0 && waited < maxc) begin
      if (core_start) starts++;
      step(); #1;
      waited++;
    end
    if (rsp_valid == '0) waited = -1;
  endtask

  task automatic wait_ack(input int maxc, output int waited);
    waited = 0;
    while (ack == '0 && waited < maxc) begin
      step(); #1;
      waited++;
    end
    if (ack == '0) waited = -1;
  endtask

  task automatic wait_idle(input int maxc, output int waited);
    waited = 0;
    while (busy && waited < maxc) begin
      step(); #1;
      waited++;
    end
    if (busy) waited = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    step(); step(); #1;
    checks++; if (ack !== 2'b00) begin errors++; $display("FAIL reset_ack got=%b exp=00", ack); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start got=%b exp=0", core_start); end
    checks++; if ({core_key, core_data, core_n} !== '0) begin errors++; $display("FAIL reset_core_ops got=%h exp=0", {core_key, core_data, core_n}); end
    checks++; if ({rsp_result, rsp_err} !== '0) begin errors++; $display("FAIL reset_rsp got=%h exp=0", {rsp_result, rsp_err}); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int waited, starts;
    lat = 3;
    set_ops(0, 43, 31, 23);
    req = 2'b01;
    #1;
    checks++; if (ack !== 2'b01) begin errors++; $display("FAIL basic_ack got=%b exp=01", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle got=%b exp=0", busy); end
    step();
    req = 2'b00;
    set_ops(0, 1, 2, 3);
    #1;
    checks++; if (ack !== 2'b00) begin errors++; $display("FAIL basic_ack_drop got=%b exp=00", ack); end
    checks++; if ({core_key, core_data, core_n} !== {6'd31, 6'd43, 6'd23}) begin errors++; $display("FAIL basic_core_ops got=%h exp=%h", {core_key, core_data, core_n}, {6'd31, 6'd43, 6'd23}); end
    wait_rsp(20, waited, starts);
    // counted from the cycle after ack: latency lat+2 minus one
    checks++; if (waited != lat + 1) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", waited, lat + 1); end
    checks++; if (starts != lat + 1) begin errors++; $display("FAIL basic_start_cycles got=%0d exp=%0d", starts, lat + 1); end
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL basic_rsp_valid got=%b exp=01", rsp_valid); end
    checks++; if ({rsp_result, rsp_err} !== {6'd5, 1'b0}) begin errors++; $display("FAIL basic_result got=%0d/%b exp=5/0", rsp_result, rsp_err); end
    step(); #1;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL basic_rsp_pulse got=%b exp=00", rsp_valid); end
    checks++; if (rsp_result !== 6'd5) begin errors++; $display("FAIL basic_result_hold got=%0d exp=5", rsp_result); end
    wait_idle(10, waited);
    checks++; if (waited < 0) begin errors++; $display("FAIL basic_idle got=busy exp=idle"); end
  endtask

  task automatic test_fairness();
    int waited, starts;
    logic [1:0] expg;
    rst = 1'b1; step(); rst = 1'b0;
    lat = 2;
    set_ops(0, 43, 31, 23);
    set_ops(1, 5, 3, 7);
    req = 2'b11;
    #1;
    for (int j = 0; j < 4; j++) begin
      expg = (j % 2 == 0) ? 2'b01 : 2'b10;
      wait_ack(10, waited);
      checks++; if (ack !== expg) begin errors++; $display("FAIL fair_grant%0d got=%b exp=%b", j, ack, expg); end
      wait_rsp(20, waited, starts);
      checks++; if (rsp_valid !== expg) begin errors++; $display("FAIL fair_rsp%0d got=%b exp=%b", j, rsp_valid, expg); end
      checks++; if (rsp_result !== ((j % 2 == 0) ? 6'd5 : 6'd6)) begin errors++; $display("FAIL fair_result%0d got=%0d exp=%0d", j, rsp_result, (j % 2 == 0) ? 5 : 6); end
      step(); #1;
    end
    req = 2'b00;
    wait_idle(10, waited);
    checks++; if (waited < 0) begin errors++; $display("FAIL fair_idle got=busy exp=idle"); end
  endtask

  task automatic test_bad_n();
    int waited;
    int starts;
    set_ops(1, 9, 9, 1);
    req = 2'b10;
    #1;
    checks++; if (ack !== 2'b10) begin errors++; $display("FAIL badn_ack got=%b exp=10", ack); end
    step();
    req = 2'b00;
    #1;
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL badn_rsp got=%b exp=10", rsp_valid); end
    checks++; if ({rsp_result, rsp_err} !== {6'd0, 1'b1}) begin errors++; $display("FAIL badn_result got=%0d/%b exp=0/1", rsp_result, rsp_err); end
    starts = 0;
    for (int t = 0; t < 4; t++) begin
      if (core_start) starts++;
      step(); #1;
    end
    checks++; if (starts != 0) begin errors++; $display("FAIL badn_core_start got=%0d exp=0", starts); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badn_idle got=%b exp=0", busy); end
    waited = 0;
  endtask

  task automatic test_drain();
    int waited, starts;
    lat = 1;
    extra_hold = 3;
    set_ops(0, 43, 31, 23);
    req = 2'b01;
    #1;
    checks++; if (ack !== 2'b01) begin errors++; $display("FAIL drain_ack got=%b exp=01", ack); end
    step(); #1;
    wait_rsp(20, waited, starts);
    checks++; if ({rsp_valid, rsp_result} !== {2'b01, 6'd5}) begin errors++; $display("FAIL drain_rsp got=%b/%0d exp=01/5", rsp_valid, rsp_result); end
    // done stays high for three more cycles: hold in DRAIN, no start, no accept
    for (int m = 1; m <= 4; m++) begin
      step(); #1;
      checks++; if ({core_start, busy, ack} !== {1'b0, 1'b1, 2'b00}) begin errors++; $display("FAIL drain_hold%0d got=%b exp=0100", m, {core_start, busy, ack}); end
    end
    step();
    extra_hold = 0;
    #1;
    checks++; if (ack !== 2'b01) begin errors++; $display("FAIL drain_regrant got=%b exp=01", ack); end
    step();
    req = 2'b00;
    #1;
    checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL drain_restart got=%b exp=1", core_start); end
    wait_rsp(20, waited, starts);
    wait_idle(10, waited);
    checks++; if (waited < 0) begin errors++; $display("FAIL drain_idle got=busy exp=idle"); end
  endtask

  task automatic test_timeout();
    int waited, starts;
    never = 1'b1;
    set_ops(0, 10, 3, 23);
    req = 2'b01;
    #1;
    checks++; if (ack !== 2'b01) begin errors++; $display("FAIL timeout_ack got=%b exp=01", ack); end
    step();
    req = 2'b00;
    #1;
    wait_rsp(30, waited, starts);
    checks++; if (starts != TO) begin errors++; $display("FAIL timeout_start_cycles got=%0d exp=%0d", starts, TO); end
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL timeout_rsp got=%b exp=01", rsp_valid); end
    checks++; if ({rsp_result, rsp_err} !== {6'd0, 1'b1}) begin errors++; $display("FAIL timeout_result got=%0d/%b exp=0/1", rsp_result, rsp_err); end
    never = 1'b0;
    wait_idle(10, waited);
    checks++; if (waited < 0 || core_start !== 1'b0) begin errors++; $display("FAIL timeout_idle got=%0d/%b exp=idle/0", waited, core_start); end
  endtask

  task automatic test_reset_mid();
    int waited, starts;
    lat = 5;
    set_ops(0, 43, 31, 23);
    set_ops(1, 5, 3, 7);
    req = 2'b01;
    #1;
    checks++; if (ack !== 2'b01) begin errors++; $display("FAIL rstmid_ack got=%b exp=01", ack); end
    step();
    req = 2'b11;
    #1;
    checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL rstmid_issue got=%b exp=1", core_start); end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if ({core_start, busy, rsp_valid} !== 4'b0000) begin errors++; $display("FAIL rstmid_abort got=%b exp=0000", {core_start, busy, rsp_valid}); end
    // pointer back at NREQ-1, so requester 0 wins over 1
    checks++; if (ack !== 2'b01) begin errors++; $display("FAIL rstmid_regrant got=%b exp=01", ack); end
    step();
    req = 2'b00;
    #1;
    wait_rsp(20, waited, starts);
    checks++; if (waited != lat + 1) begin errors++; $display("FAIL rstmid_latency got=%0d exp=%0d", waited, lat + 1); end
    checks++; if ({rsp_valid, rsp_result, rsp_err} !== {2'b01, 6'd5, 1'b0}) begin errors++; $display("FAIL rstmid_rsp got=%b/%0d/%b exp=01/5/0", rsp_valid, rsp_result, rsp_err); end
    for (int t = 0; t < 6; t++) begin
      step(); #1;
      checks++; if ({ack, rsp_valid} !== 4'b0000) begin errors++; $display("FAIL rstmid_quiet%0d got=%b exp=0000", t, {ack, rsp_valid}); end
    end
  endtask

  // Transaction-level model: free/busy windows, RR order, latency and results.
  task automatic test_random();
    int last = 1, c0 = -1, rsp_at = -1, free_at = 0, pend_g = 0;
    int exp_res = 0, g = 0, d, k, n;
    bit pend = 1'b0, good = 1'b0, exp_err = 1'b0;
    logic [1:0] acked = '0, exp_ack, exp_rv;
    logic exp_busy, exp_start;
    rst = 1'b1; req = '0; step(); rst = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      lat = 1 + int'($urandom % 5);
      for (int i = 0; i < 2; i++) begin
        if (acked[i] || (!req[i] && ($urandom % 4 == 0))) begin
          req[i] = acked[i] ? 1'($urandom % 2) : 1'b1;
          n = ($urandom % 8 == 0) ? int'($urandom % 2) : int'($urandom % 64);
          set_ops(i, int'($urandom % 64), int'($urandom % 64), n);
        end
      end
      #1;
      exp_ack = '0;
      if (cyc >= free_at && req != '0) begin
        g = rr(req, last);
        exp_ack = 2'(1) << g;
      end
      checks++; if (ack !== exp_ack) begin errors++; $display("FAIL rand_ack cyc=%0d got=%b exp=%b", cyc, ack, exp_ack); end
      if (exp_ack != '0) begin
        d = int'(req_data[g*W +: W]);
        k = int'(req_key[g*W +: W]);
        n = int'(req_n[g*W +: W]);
        last = g; c0 = cyc; pend = 1'b1; pend_g = g;
        good = (n >= 2);
        rsp_at = good ? cyc + lat + 2 : cyc + 1;
        exp_res = modexp(d, k, n);
        exp_err = !good;
        free_at = rsp_at + 2;
      end
      exp_rv = (pend && cyc == rsp_at) ? 2'(1) << pend_g : 2'b00;
      checks++; if (rsp_valid !== exp_rv) begin errors++; $display("FAIL rand_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rv); end
      if (exp_rv != '0) begin
        pend = 1'b0;
        checks++; if ({rsp_result, rsp_err} !== {W'(exp_res), exp_err}) begin errors++; $display("FAIL rand_result cyc=%0d got=%0d/%b exp=%0d/%b", cyc, rsp_result, rsp_err, exp_res, exp_err); end
      end
      exp_busy  = (cyc > c0) && (cyc < free_at);
      exp_start = good && (cyc > c0) && (cyc < rsp_at);
      checks++; if ({busy, core_start} !== {exp_busy, exp_start}) begin errors++; $display("FAIL rand_busy_start cyc=%0d got=%b exp=%b", cyc, {busy, core_start}, {exp_busy, exp_start}); end
      acked = ack;
      step();
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fairness();
    test_bad_n();
    test_drain();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
